// File: rtl/spinner_decoder.sv
// Quadrature decoder for the Arkanoid spinner: synchronise and glitch-filter the
// AB levels, decode each Gray-code transition into a signed step, accumulate a wrapping count.
module spinner_decoder #(
  parameter int CNT_W = 8,
  parameter int FILT  = 2
) (
  input  logic             clk_12m,
  input  logic             reset,
  input  logic [1:0]       spinner,
  input  logic             clr,
  input  logic             rd,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] dout,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam int HW = (FILT > 1) ? FILT - 1 : 1;

  typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DN, MV_BAD} mv_t;

  logic [1:0]          s1, s2, f;
  logic [HW-1:0][1:0]  hist;
  logic [FILT:0]       vld_pipe;
  logic                p;
  logic                all_eq, stable, acc;
  mv_t                 mv;

  // s2 plus the FILT-1 previous s2 samples form the filter window
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < FILT - 1; i++)
      if (hist[i] != s2) all_eq = 1'b0;
  end

  // Reset-time contents of the chain are not real samples; priming waits until
  // the whole window has been refilled from the pin, so a level held through
  // reset is adopted silently instead of being decoded as a move from 11.
  assign stable = all_eq & vld_pipe[FILT];

  always_comb begin
    mv = MV_NONE;
    case ({f, s2})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: mv = MV_UP;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: mv = MV_DN;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: mv = MV_BAD;
      default:                            mv = MV_NONE;
    endcase
  end

  assign acc = stable & p & (mv != MV_NONE);

  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      s1       <= 2'b11;
      s2       <= 2'b11;
      hist     <= {HW{2'b11}};
      vld_pipe <= '0;
      f        <= 2'b11;
      p        <= 1'b0;
      count    <= '0;
      dout     <= '0;
      step     <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      s1      <= spinner;
      s2      <= s1;
      hist[0] <= s2;
      for (int i = 1; i < HW; i++) hist[i] <= hist[i-1];
      vld_pipe <= {vld_pipe[FILT-1:0], 1'b1};

      if (rd) dout <= count;

      step <= acc & ((mv == MV_UP) | (mv == MV_DN));

      if (stable && !p) begin
        f <= s2;
        p <= 1'b1;
      end else if (acc) begin
        f <= s2;
      end

      if (acc && mv == MV_UP)      dir <= 1'b1;
      else if (acc && mv == MV_DN) dir <= 1'b0;

      // clear wins over a same-edge count/err effect
      if (clr) begin
        count <= '0;
        err   <= 1'b0;
      end else if (acc) begin
        case (mv)
          MV_UP:   count <= count + 1'b1;
          MV_DN:   count <= count - 1'b1;
          MV_BAD:  err   <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spinner_decoder.md
# spinner_decoder

Quadrature decoder for the Arkanoid spinner (paddle) input. It takes the 2-bit AB encoder levels driven onto the board's `spinner` input, synchronises and glitch-filters them, then decodes each Gray-code transition into a signed step. Steps accumulate in a wrapping position counter, which the CPU input-port logic samples through a read strobe. It sits inside the `arkanoid` core between the `spinner[1:0]` input and the CPU data bus mux, in the 12 MHz domain.

## Interface
Parameters:
- `CNT_W`, 8: position counter width in bits.
- `FILT`, 2: consecutive identical synchronised samples required to accept a new AB level. Legal range 1..15.

Ports:
- `clk_12m`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-low.
- `spinner`, in, 2: asynchronous encoder levels {A,B}. Idle level is 2'b11.
- `clr`, in, 1: synchronous clear of `count` and `err`.
- `rd`, in, 1: read strobe. Latches `count` into `dout`.
- `count`, out, CNT_W: live position counter.
- `dout`, out, CNT_W: count value latched on the last `rd`.
- `step`, out, 1: one-cycle pulse for each accepted legal step.
- `dir`, out, 1: direction of the last legal step. 1 = up, 0 = down.
- `err`, out, 1: sticky flag for an illegal (double-bit) transition.

## Operation
- Synchroniser: 2-FF chain `s1`→`s2` on `spinner`.
- Filter: history of the last FILT `s2` samples. Candidate value `c` is accepted when all FILT samples are equal and differ from the filtered phase `f`.
- Primed flag `p`, cleared by reset:
  - While `p`=0, the first value satisfying the all-equal condition loads `f` (even if it already equals `f`) and sets `p`.
  - That load produces no step, no count change and no err.
- Decode on acceptance, using {f_old, c}:
  - +1 (count up, dir←1): 00→10, 10→11, 11→01, 01→00. This is positive mouse-X motion.
  - −1 (count down, dir←0): 00→01, 01→11, 11→10, 10→00.
  - Illegal: 00↔11, 01↔10. `err`←1, count and dir unchanged, no step, f←c.
- Counter arithmetic is mod 2^CNT_W. 0xFF+1 wraps to 0x00 and 0x00−1 wraps to 0xFF (CNT_W=8).
- `clr`: count←0 and err←0. Takes priority over a same-cycle step or illegal event; that event's count or err effect is discarded, but f, dir and step still update.
- `rd`: dout←count value before the edge. With simultaneous rd and step, dout gets the pre-step value. With simultaneous rd and clr, dout gets the old count.
- Reset values:
  - `count`=0, `dout`=0, `step`=0, `dir`=0, `err`=0, `p`=0.
  - `s1`, `s2`, history and `f` = 2'b11.
- Reset asserted mid-motion aborts everything. After release the decoder re-primes on the first stable level, so there is no spurious step.

## Timing
- Edge k is the first edge sampling a new level into `s1`. `s2` holds the level after edge k+1.
- Acceptance edge is k+1+FILT, provided the level is held. `count`, `dir`, `step` and `err` update at that edge.
  - FILT=2: visible after k+3.
- `s2` pulses shorter than FILT cycles are rejected.
- Minimum spacing between accepted steps is FILT cycles at `s2`.
- `step` is high for exactly the one cycle following the acceptance edge.
- `dout` is valid the cycle after `rd`.
- `err` holds until `clr` or reset.

## Test plan
1. Reset, spinner=11. Step 11→01→00→10→11, each held 4 cycles (FILT=2) -> 4 `step` pulses, `count`=4, `dir`=1, `err`=0. First update 3 edges after the first change.
2. From count 0, step 11→10→00→01→11 -> `count`=0xFC (wrap), `dir`=0, 4 pulses.
3. FILT=2, spinner 11 with a 1-cycle glitch to 01 -> no `step`, `count` unchanged. Repeat with a 2-cycle hold -> `count`+1.
4. Jump 11→00 and hold -> `count` unchanged, no `step`, `err`=1 and stays 1 through later legal steps. Then `clr` -> `count`=0, `err`=0.
5. `count`=5. Legal +1 step accepted on the same edge as `rd`=1 -> `dout`=5, `count`=6. Step plus `clr` on the same edge -> `count`=0, `step` pulses.
6. Assert reset while spinner=01 mid-sequence, release -> after priming no `step` and `count`=0. Then 01→00 -> `count`=1, `dir`=1.
